// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control sequencer: ALUOp and funct
// codes, ALU control encodings, FSM state type and the decode helper.
package alu_ctrl_pkg;

  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CODE_W  = 4;

  // Main-decoder op classes
  localparam logic [ALUOP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] OP_RTYPE = 3'b010;
  localparam logic [ALUOP_W-1:0] OP_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] OP_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] OP_SLT   = 3'b101;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] F_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] F_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] F_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] F_NOR   = 6'h27;
  localparam logic [FUNCT_W-1:0] F_SLT   = 6'h2A;

  // ALU control encodings
  localparam logic [CODE_W-1:0] CNT_AND     = 4'b0000;
  localparam logic [CODE_W-1:0] CNT_OR      = 4'b0001;
  localparam logic [CODE_W-1:0] CNT_ADD     = 4'b0010;
  localparam logic [CODE_W-1:0] CNT_SUB     = 4'b0110;
  localparam logic [CODE_W-1:0] CNT_SLT     = 4'b0111;
  localparam logic [CODE_W-1:0] CNT_SLL     = 4'b1000;
  localparam logic [CODE_W-1:0] CNT_SRL     = 4'b1001;
  localparam logic [CODE_W-1:0] CNT_MULT    = 4'b1010;
  localparam logic [CODE_W-1:0] CNT_MULTU   = 4'b1011;
  localparam logic [CODE_W-1:0] CNT_NOR     = 4'b1100;
  localparam logic [CODE_W-1:0] CNT_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [CODE_W-1:0] cnt;
    logic              illegal;
    logic              is_mul;
    logic              mul_signed;
  } dec_t;

  // Pure decode of ALUOp/funct; unknown encodings fall through to illegal.
  function automatic dec_t decode(input logic [ALUOP_W-1:0] aluop,
                                  input logic [FUNCT_W-1:0] funct);
    dec_t d;
    d.cnt        = CNT_ILLEGAL;
    d.illegal    = 1'b1;
    d.is_mul     = 1'b0;
    d.mul_signed = 1'b0;
    case (aluop)
      OP_ADD: begin d.cnt = CNT_ADD; d.illegal = 1'b0; end
      OP_SUB: begin d.cnt = CNT_SUB; d.illegal = 1'b0; end
      OP_AND: begin d.cnt = CNT_AND; d.illegal = 1'b0; end
      OP_OR:  begin d.cnt = CNT_OR;  d.illegal = 1'b0; end
      OP_SLT: begin d.cnt = CNT_SLT; d.illegal = 1'b0; end
      OP_RTYPE: begin
        d.illegal = 1'b0;
        case (funct)
          F_ADD:   d.cnt = CNT_ADD;
          F_SUB:   d.cnt = CNT_SUB;
          F_AND:   d.cnt = CNT_AND;
          F_OR:    d.cnt = CNT_OR;
          F_NOR:   d.cnt = CNT_NOR;
          F_SLT:   d.cnt = CNT_SLT;
          F_SLL:   d.cnt = CNT_SLL;
          F_SRL:   d.cnt = CNT_SRL;
          F_MULT:  begin d.cnt = CNT_MULT;  d.is_mul = 1'b1; d.mul_signed = 1'b1; end
          F_MULTU: begin d.cnt = CNT_MULTU; d.is_mul = 1'b1; end
          default: begin d.cnt = CNT_ILLEGAL; d.illegal = 1'b1; end
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Radix-2 Booth multiplier, one iteration per clock over WIDTH+1 iterations.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start_i         load operands and begin (ignored when flush_i is high)
//   signed_i        1: sign-extend operands, 0: zero-extend
//   flush_i         abort a running multiply
//   a_i, b_i        multiplicand / multiplier
//   done_c_o        high during the cycle whose edge performs the last iteration
//   product_c_o     low 2*WIDTH bits of {A,Q} after that iteration
module booth_seq_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_c_o,
  output logic [2*WIDTH-1:0] product_c_o
);

  localparam int unsigned EXT_W  = WIDTH + 1;
  localparam int unsigned ACC_W  = WIDTH + 2;
  localparam int unsigned ITER_W = $clog2(WIDTH + 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [EXT_W-1:0]  q_q, q_d;
  logic [EXT_W-1:0]  m_q, m_d;
  logic              qm1_q, qm1_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;

  logic [ACC_W-1:0]  m_ext;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  acc_sh;
  logic [EXT_W-1:0]  q_sh;

  // One Booth step: add/subtract M by {q0,q-1}, then arithmetic shift of {A,Q}
  always_comb begin
    m_ext = {m_q[EXT_W-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    acc_sh      = {sum[ACC_W-1], sum[ACC_W-1:1]};
    q_sh        = {sum[0], q_q[EXT_W-1:1]};
    product_c_o = {acc_sh[WIDTH-2:0], q_sh};
    done_c_o    = busy_q & last_q;
  end

  // Operand load, iteration and abort
  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    m_d    = m_q;
    qm1_d  = qm1_q;
    iter_d = iter_q;
    last_d = last_q;
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = 1'b0;
      last_d = 1'b0;
    end else if (start_i) begin
      acc_d  = '0;
      m_d    = signed_i ? {a_i[WIDTH-1], a_i} : {1'b0, a_i};
      q_d    = signed_i ? {b_i[WIDTH-1], b_i} : {1'b0, b_i};
      qm1_d  = 1'b0;
      iter_d = '0;
      last_d = 1'b0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d  = acc_sh;
      q_d    = q_sh;
      qm1_d  = q_q[0];
      iter_d = ITER_W'(iter_q + 1'b1);
      // last_q flags the WIDTH+1-th iteration, i.e. iter_q == WIDTH
      last_d = (iter_q == ITER_W'(WIDTH - 1));
      busy_d = ~last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
      qm1_q  <= 1'b0;
      iter_q <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      q_q    <= q_d;
      m_q    <= m_d;
      qm1_q  <= qm1_d;
      iter_q <= iter_d;
      last_q <= last_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control decoder with a sequential Booth multiplier for
// mult/multu; stalls the pipeline while the multiply is in flight.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   valid_in              decode request, taken only when ready=1
//   ALUOp, funct          op class / R-type function field
//   op_a, op_b            multiply operands, sampled on an accepted mult
//   flush                 synchronous abort
//   ready / stall         FSM idle / busy (decoded from state register)
//   ALUCnt, illegal       registered control code and illegal flag
//   cnt_valid             one-cycle pulse per accepted request
//   mul_done              one-cycle pulse when prod_hi/prod_lo update
//   prod_hi, prod_lo      last completed product
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             ready,
  output logic [CNT_W-1:0] ALUCnt,
  output logic             cnt_valid,
  output logic             illegal,
  output logic             stall,
  output logic             mul_done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   alucnt_q, alucnt_d;
  logic               illegal_q, illegal_d;
  logic               cnt_valid_q, cnt_valid_d;
  logic               mul_done_q, mul_done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  dec_t               dec;
  logic               core_start;
  logic               core_done;
  logic [2*WIDTH-1:0] core_product;

  booth_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (core_start),
    .signed_i    (dec.mul_signed),
    .flush_i     (flush),
    .a_i         (op_a),
    .b_i         (op_b),
    .done_c_o    (core_done),
    .product_c_o (core_product)
  );

  // Next state and registered outputs; flush overrides everything
  always_comb begin
    dec         = decode(ALUOp, funct);
    state_d     = state_q;
    alucnt_d    = alucnt_q;
    illegal_d   = illegal_q;
    cnt_valid_d = 1'b0;
    mul_done_d  = 1'b0;
    prod_d      = prod_q;
    core_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && !flush) begin
          alucnt_d    = CNT_W'(dec.cnt);
          illegal_d   = dec.illegal;
          cnt_valid_d = 1'b1;
          if (dec.is_mul) begin
            core_start = 1'b1;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (core_done) begin
          state_d    = DONE;
          mul_done_d = 1'b1;
          prod_d     = core_product;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alucnt_q    <= '0;
      illegal_q   <= 1'b0;
      cnt_valid_q <= 1'b0;
      mul_done_q  <= 1'b0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      alucnt_q    <= alucnt_d;
      illegal_q   <= illegal_d;
      cnt_valid_q <= cnt_valid_d;
      mul_done_q  <= mul_done_d;
      prod_q      <= prod_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign stall     = ~ready;
  assign ALUCnt    = alucnt_q;
  assign illegal   = illegal_q;
  assign cnt_valid = cnt_valid_q;
  assign mul_done  = mul_done_q;
  assign prod_hi   = prod_q[2*WIDTH-1:WIDTH];
  assign prod_lo   = prod_q[WIDTH-1:0];

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised, registered successor to the pipeline's ALU control decoder. It sits in the EX stage. It decodes ALUOp/funct into the ALU control code and flags illegal encodings. For `mult`/`multu` it also runs a multi-cycle radix-2 Booth multiply over a WIDTH-bit datapath. While that multiply runs, it stalls the pipeline.

## Interface
- WIDTH, 32: operand width; product is 2*WIDTH.
- CNT_W, 4: ALU control code width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  decode request; accepted only when ready=1.
- ALUOp  in  3  main-decoder op class.
- funct  in  6  R-type function field.
- op_a  in  WIDTH  multiplicand, sampled on an accepted mult.
- op_b  in  WIDTH  multiplier, sampled on an accepted mult.
- flush  in  1  synchronous abort of a pending or running op.
- ready  out  1  1 when FSM is IDLE.
- ALUCnt  out  CNT_W  registered control code.
- cnt_valid  out  1  one-cycle pulse with each new ALUCnt.
- illegal  out  1  registered alongside ALUCnt; 1 if the encoding is unknown.
- stall  out  1  1 while FSM is in RUN or DONE.
- mul_done  out  1  one-cycle pulse when prod_hi/prod_lo are updated.
- prod_hi, prod_lo  out  WIDTH each  last completed product; held between ops.

## Operation
- ALUOp decode:
  - 000 → 0010 (add)
  - 001 → 0110 (sub)
  - 011 → 0000 (and)
  - 100 → 0001 (or)
  - 101 → 0111 (slt)
  - 010 → decode by funct
  - 110/111 → 1111 with illegal=1
- funct decode:
  - 0x20 → 0010
  - 0x22 → 0110
  - 0x24 → 0000
  - 0x25 → 0001
  - 0x27 → 1100
  - 0x2A → 0111
  - 0x00 → 1000 (sll)
  - 0x02 → 1001 (srl)
  - 0x18 → 1010, starts a signed multiply
  - 0x19 → 1011, starts an unsigned multiply
  - any other → 1111 with illegal=1
- FSM states:
  - IDLE: accept on valid_in & ~flush. A non-multiply goes to IDLE; a multiply goes to RUN.
  - RUN: performs WIDTH+1 Booth iterations, tracked by an iteration counter. Goes to DONE after the last one.
  - DONE: asserts mul_done and loads prod_hi/prod_lo; goes to IDLE.
- Booth arithmetic:
  - Operands are extended to WIDTH+1 bits: sign-extended for 0x18, zero-extended for 0x19.
  - Accumulator is WIDTH+2 bits. Each iteration examines the pair {q0, q-1}: 01 adds M, 10 subtracts M, 00/11 do nothing; then an arithmetic right shift.
  - Result is the low 2*WIDTH bits of the final {A,Q}.
- flush:
  - Any state → IDLE on the next edge. No mul_done pulse; prod_hi/prod_lo are not updated.
  - flush together with valid_in in IDLE: flush wins; nothing is accepted and there is no cnt_valid.
- valid_in while ready=0 is ignored. Upstream holds the request until ready=1.
- Reset values:
  - FSM = IDLE, ready=1.
  - ALUCnt=0000, illegal=0, cnt_valid=0, stall=0, mul_done=0.
  - prod_hi=0, prod_lo=0; iteration counter cleared.
- Reset asserted mid-multiply aborts immediately: all outputs return to their reset values asynchronously.

## Timing
- Latency of the decode outputs:
  - Edge E0 accepts the request.
  - ALUCnt, illegal and cnt_valid are valid in the cycle after E0; cnt_valid lasts one cycle.
  - For a multiply, ALUCnt also appears after E0.
- Multiply:
  - RUN covers edges E1..E(WIDTH+1); DONE is entered at E(WIDTH+1).
  - mul_done and the new prod_hi/prod_lo are visible in the cycle after E(WIDTH+1).
  - IDLE is reached at E(WIDTH+2).
  - For WIDTH=32, mul_done is visible after E33 and ready=1 again after E34.
- stall equals ~ready and is a combinational decode of the state register. It rises the cycle after E0 and falls the cycle after E(WIDTH+2).
- Back-to-back non-multiply requests are accepted every cycle.

## Structure
- Package alu_ctrl_pkg holds:
  - ALUOp codes.
  - funct codes.
  - ALUCnt encodings, including CNT_ILLEGAL=4'b1111.
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module booth_seq_core (parameter WIDTH) contains the A/Q/M registers, the q-1 bit, the iteration counter and the last flag. Its handshake is start/signed_op/flush in, done/product out.
- The top level keeps the decoder, the FSM and the output registers.

## Test plan
- Sweep ALUOp 0..7 with funct=0x20, then ALUOp=010 with funct 0x00..0x2A → every listed code matches; others give 1111 with illegal=1; one cnt_valid per accept.
- mult with op_a=0xFFFFFFFD, op_b=7 → prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFEB; mul_done visible after E33; stall high for exactly 34 cycles.
- multu with op_a=0xFFFFFFFF, op_b=2 → prod_hi=0x00000001, prod_lo=0xFFFFFFFE. Then mult with the same operands → prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFFE.
- flush at E10 of a mult started after a completed 6*7 → IDLE at E11; no mul_done; prod_lo stays 42.
- valid_in held during RUN with funct=0x22 → ignored until ready=1, then accepted; ALUCnt=0110 one cycle later.
- rst_n dropped at E15 of a mult → all outputs at reset values immediately; the first request after release decodes normally.
